spi_peripheral_byte: RTL and testbench
======================================

Name: spi_peripheral_byte

Overview:
- SPI peripheral (target) byte engine: the responding end of the SPI byte shifter, used as the card-side model in SD testbenches and as a generic SPI target.
- Oversamples sclk, mosi and cs_n in the system clock domain.
- Deserialises mosi bytes to a one-cycle valid strobe and serialises queued bytes onto miso.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first: mosi sampled on sclk rise, miso updated on sclk fall.

Parameters:
FILL_BYTE, 8'hFF, byte shifted out when no transmit data is queued (SD idle pattern).
SYNC_STAGES, 2, flop stages on sclk/mosi/cs_n; legal values are 2 or 3.

Ports:
clock  input  1  system clock; all logic is on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
sclk  input  1  SPI clock from the initiator; asynchronous to clock.
mosi  input  1  serial data from the initiator.
cs_n  input  1  active-low select from the initiator.
miso  output  1  serial data to the initiator.
miso_oe  output  1  miso drive enable; high while selected.
tx_data  input  8  next byte to send.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  holding register empty; a byte is accepted when tx_valid & tx_ready.
rx_data  output  8  last complete received byte; holds until the next byte completes.
rx_valid  output  1  one-cycle pulse when rx_data updates.
tx_underrun  output  1  one-cycle pulse when FILL_BYTE is loaded at a byte boundary inside a transaction.
selected  output  1  synchronised cs_n is low.

Behaviour:
- Reset: the single clock is clock; reset_n is asynchronous and active-low. All flops clear. Output reset values: miso=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, selected=0. Holding register empty, bit counter 0.
- Sync: sclk, mosi and cs_n each pass through SYNC_STAGES flops. Edges are detected from the last synced stage and the flop after it. Timing requirement: sclk high and low time must each be at least 4 clock periods, and cs_n setup to the first sclk rise must be at least 4 clock periods.
- States:
  - IDLE: synced cs_n high. miso_oe=0. bit_cnt=0. Edges on sclk are ignored.
  - LOAD: one cycle, entered on the synced cs_n falling edge. The shift register loads the holding byte if the holding register is full (holding becomes empty), else FILL_BYTE with no underrun pulse. Go to ACTIVE.
  - ACTIVE:
    - miso = shift_reg[7]; miso_oe=1.
    - Synced sclk rise: rx_shift <= {rx_shift[6:0], mosi_synced}; bit_cnt++. When bit_cnt goes 7->0, rx_data <= the completed byte and rx_valid pulses in that same cycle.
    - Synced sclk fall: if bit_cnt != 0, shift_reg <= {shift_reg[6:0], 1'b0}. If bit_cnt == 0 (byte boundary), reload from the holding register, or from FILL_BYTE with a tx_underrun pulse.
- Latency:
  - miso changes 1 clock after a detected synced sclk fall, i.e. SYNC_STAGES+1 clocks after the pin edge.
  - rx_valid asserts SYNC_STAGES+1 clocks after the 8th sclk rise.
- Holding register: one deep; tx_ready = ~hold_full. Loads use the holding state at the start of the cycle. If an accept and a load coincide while the holding register is empty, FILL_BYTE is loaded and the accepted byte stays held for the following byte.
- cs_n deassert mid-byte (synced rise, any bit_cnt): return to IDLE, discard the partial rx byte (no rx_valid), zero bit_cnt, set miso=1, set miso_oe=0. The holding register is retained. A shift-register byte that was partly sent is dropped.
- cs_n deassert exactly after the 8th rise: rx_valid still pulses for that byte.
- Simultaneous sclk edge and cs_n rise in the same synced cycle: the cs_n rise wins; the edge is ignored.
- Back-to-back transactions: re-selection re-enters LOAD. Every transaction starts byte-aligned.
- reset_n asserted mid-transfer: immediate clear to reset values, regardless of the SPI pins.

Test Plan:
- Reset, hold cs_n=1, toggle sclk -> miso_oe=0, miso=1, tx_ready=1, no rx_valid.
- Queue tx 8'hA5, assert cs_n, initiator sends 8'h3C with sclk half-period 4 clocks -> miso bits 1,0,1,0,0,1,0,1 sampled on rises; rx_data=8'h3C with one rx_valid pulse; tx_ready re-asserts in the LOAD cycle.
- Queue 8'h01 then 8'h02 back-to-back, clock 3 bytes in, mosi 8'h11,8'h22,8'h33 -> miso shows 01,02,FF; tx_underrun pulses once, at the boundary before the third byte; rx_valid pulses 3 times with 11,22,33.
- No tx queued, select, 1 byte -> miso=8'hFF, no tx_underrun (first load), rx_data captured.
- Deassert cs_n after 5 sclk rises -> no rx_valid, miso_oe falls; re-select and send 8'hC3 -> rx_data=8'hC3 (alignment restored).
- Pulse reset_n low mid-byte with the holding register full -> all outputs return to reset values; tx_ready=1; after re-select miso=8'hFF.

Source files
------------

// File: rtl/spi_peripheral_byte_if.sv
// Byte-engine bus for the SPI peripheral: SPI pins plus the tx/rx byte handshakes.
interface spi_peripheral_byte_if;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       selected;

    // Initiator / system side drives the pins and the transmit byte.
    modport master (
        output sclk, mosi, cs_n, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, selected
    );

    // Peripheral byte engine.
    modport slave (
        input  sclk, mosi, cs_n, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, selected
    );
endinterface

// File: rtl/spi_peripheral_byte.sv
// SPI mode-0 target byte engine: oversampled pins, MSB-first rx deserialiser and
// tx serialiser with a one-deep holding register and FILL_BYTE on underrun.
module spi_peripheral_byte #(
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    spi_peripheral_byte_if.slave  bus
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]       shift_q, shift_d;
    logic [BYTE_W-2:0]       rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]       rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    underrun_q, underrun_d;
    logic [BYTE_W-1:0]       hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    tx_ready_q, tx_ready_d;
    logic                    miso_q, miso_d;
    logic                    miso_oe_q, miso_oe_d;
    logic                    selected_q, selected_d;

    logic sclk_s_c, mosi_s_c, cs_s_c;
    logic sclk_rise_c, sclk_fall_c;
    logic accept_c, take_hold_c;

    // Last synchroniser stage feeds edge detection and the datapath.
    assign sclk_s_c    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s_c    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s_c      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_c = ~sclk_prev_q & sclk_s_c;
    assign sclk_fall_c = sclk_prev_q & ~sclk_s_c;
    assign accept_c    = bus.tx_valid & ~hold_full_q;

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        sclk_prev_d = sclk_s_c;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        take_hold_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!cs_s_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (cs_s_c) begin
                    state_d = ST_IDLE;
                end else begin
                    // First byte of a transaction never counts as an underrun.
                    shift_d     = hold_full_q ? hold_q : FILL_BYTE;
                    take_hold_c = hold_full_q;
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_s_c) begin
                    // Deselect wins over any coincident sclk edge; partial bytes are dropped.
                    state_d    = ST_IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (sclk_rise_c) begin
                    rx_shift_d = {rx_shift_q[BYTE_W-3:0], mosi_s_c};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                        rx_data_d  = {rx_shift_q, mosi_s_c};
                        rx_valid_d = 1'b1;
                    end
                end else if (sclk_fall_c) begin
                    if (bit_cnt_q != '0) begin
                        shift_d = {shift_q[BYTE_W-2:0], 1'b0};
                    end else if (hold_full_q) begin
                        shift_d     = hold_q;
                        take_hold_c = 1'b1;
                    end else begin
                        shift_d    = FILL_BYTE;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Loads see the holding state from the start of the cycle; accept only when empty.
        if (take_hold_c) hold_full_d = 1'b0;
        if (accept_c) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        tx_ready_d = ~hold_full_d;
        miso_oe_d  = (state_d == ST_ACTIVE);
        miso_d     = (state_d == ST_ACTIVE) ? shift_d[BYTE_W-1] : 1'b1;
        selected_d = ~cs_sync_d[SYNC_STAGES-1];
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            selected_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ready_q  <= tx_ready_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            selected_q  <= selected_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.miso_oe     = miso_oe_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.selected    = selected_q;

endmodule

// File: tb/tb_spi_peripheral_byte.sv
// Self-checking bench for spi_peripheral_byte: table of single-byte transactions
// plus hand-written multi-byte, abort, late-deselect and reset sequences.
module tb_spi_peripheral_byte;

    localparam int unsigned HALF  = 4;
    localparam int unsigned SETUP = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_peripheral_byte_if bus ();

    spi_peripheral_byte #(
        .FILL_BYTE   (8'hFF),
        .SYNC_STAGES (2)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         queue_tx;
        logic [7:0] tx_byte;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         un_cnt = 0;
    logic [7:0] rx_obs[$];
    logic [7:0] rx_exp[$];
    vec_t       vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        int n;
        n = 0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 64) begin
            clks(1);
            n++;
        end
        if (!bus.tx_ready) begin
            checks++;
            errors++;
            $display("FAIL tx_accept_timeout: tx_ready never rose for %0h", b);
        end
        clks(1);
        bus.tx_valid = 1'b0;
    endtask

    // Mode-0 initiator: mosi set while sclk low, miso sampled at the rising edge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit last_fall,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            clks(HALF);
            mi[7-i]  = bus.miso;
            bus.sclk = 1'b1;
            clks(HALF);
            if (i < nbits - 1 || last_fall) bus.sclk = 1'b0;
        end
    endtask

    task automatic check_rx(input string name);
        chk({name, "_rx_count"}, 32'(rx_obs.size()), 32'(rx_exp.size()));
        while (rx_obs.size() > 0 && rx_exp.size() > 0)
            chk({name, "_rx_data"}, 32'(rx_obs.pop_front()), 32'(rx_exp.pop_front()));
        rx_obs.delete();
        rx_exp.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] mi, m0, m1, m2;
        int u0;

        fork
            forever begin
                @(negedge clk);
                if (bus.rx_valid)    rx_obs.push_back(bus.rx_data);
                if (bus.tx_underrun) un_cnt++;
            end
        join_none

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{1'b1, 8'h81, 8'h00, 8'h81};

        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.cs_n = 1'b1;
        bus.tx_data = '0; bus.tx_valid = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(2);

        chk("rst_miso", 32'(bus.miso), 32'd1);
        chk("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rst_selected", 32'(bus.selected), 32'd0);

        // Deselected: sclk activity must be ignored.
        for (int i = 0; i < 8; i++) begin
            bus.sclk = 1'b1; clks(HALF);
            bus.sclk = 1'b0; clks(HALF);
        end
        chk("idle_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("idle_miso", 32'(bus.miso), 32'd1);
        chk("idle_rx_pulses", 32'(rx_obs.size()), 32'd0);
        chk("idle_underrun", 32'(un_cnt), 32'd0);

        foreach (vecs[v]) begin
            if (vecs[v].queue_tx) begin
                push_tx(vecs[v].tx_byte);
                chk("vec_hold_full", 32'(bus.tx_ready), 32'd0);
            end
            bus.cs_n = 1'b0;
            clks(SETUP);
            chk("vec_selected", 32'(bus.selected), 32'd1);
            chk("vec_miso_oe", 32'(bus.miso_oe), 32'd1);
            chk("vec_tx_ready_after_load", 32'(bus.tx_ready), 32'd1);
            u0 = un_cnt;
            rx_exp.push_back(vecs[v].mosi_byte);
            spi_bits(vecs[v].mosi_byte, 8, 1'b0, mi);
            clks(HALF);
            chk("vec_first_load_no_underrun", 32'(un_cnt - u0), 32'd0);
            chk("vec_miso_byte", 32'(mi), 32'(vecs[v].exp_miso));
            check_rx("vec");
            bus.sclk = 1'b0;
            clks(HALF);
            bus.cs_n = 1'b1;
            clks(HALF);
            chk("vec_deselect_oe", 32'(bus.miso_oe), 32'd0);
            chk("vec_deselect_miso", 32'(bus.miso), 32'd1);
            chk("vec_rx_data_hold", 32'(bus.rx_data), 32'(vecs[v].mosi_byte));
        end

        // Three bytes: two queued, third falls back to FILL_BYTE with one underrun.
        push_tx(8'h01);
        bus.cs_n = 1'b0;
        clks(SETUP);
        push_tx(8'h02);
        chk("multi_hold_full", 32'(bus.tx_ready), 32'd0);
        u0 = un_cnt;
        rx_exp.push_back(8'h11); rx_exp.push_back(8'h22); rx_exp.push_back(8'h33);
        spi_bits(8'h11, 8, 1'b1, m0);
        spi_bits(8'h22, 8, 1'b1, m1);
        spi_bits(8'h33, 8, 1'b0, m2);
        clks(HALF);
        chk("multi_miso0", 32'(m0), 32'h01);
        chk("multi_miso1", 32'(m1), 32'h02);
        chk("multi_miso2", 32'(m2), 32'hFF);
        chk("multi_underrun_count", 32'(un_cnt - u0), 32'd1);
        check_rx("multi");
        chk("multi_tx_ready", 32'(bus.tx_ready), 32'd1);
        bus.sclk = 1'b0;
        clks(HALF);
        bus.cs_n = 1'b1;
        clks(HALF);

        // Abort after 5 bits; holding register must survive the deselect.
        push_tx(8'h5E);
        bus.cs_n = 1'b0;
        clks(SETUP);
        push_tx(8'h77);
        spi_bits(8'hAB, 5, 1'b1, mi);
        clks(HALF);
        bus.cs_n = 1'b1;
        clks(HALF);
        chk("abort_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("abort_miso", 32'(bus.miso), 32'd1);
        chk("abort_selected", 32'(bus.selected), 32'd0);
        chk("abort_hold_kept", 32'(bus.tx_ready), 32'd0);
        check_rx("abort");

        // Reselect: realigned byte; deselect one clock after the 8th rise still delivers it.
        bus.cs_n = 1'b0;
        clks(SETUP);
        rx_exp.push_back(8'hC3);
        spi_bits(8'hC3, 8, 1'b0, mi);
        clks(1);
        bus.cs_n = 1'b1;
        clks(HALF);
        chk("realign_miso", 32'(mi), 32'h77);
        check_rx("realign");
        u0 = un_cnt;
        bus.sclk = 1'b0;
        clks(HALF);
        chk("idle_fall_ignored", 32'(un_cnt - u0), 32'd0);

        // Reset mid-byte with the holding register full.
        push_tx(8'h12);
        bus.cs_n = 1'b0;
        clks(SETUP);
        push_tx(8'h34);
        chk("rstmid_hold_full", 32'(bus.tx_ready), 32'd0);
        spi_bits(8'h9C, 3, 1'b0, mi);
        clks(2);
        rst_n = 1'b0;
        #2;
        chk("rstmid_miso", 32'(bus.miso), 32'd1);
        chk("rstmid_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("rstmid_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rstmid_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rstmid_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rstmid_underrun", 32'(bus.tx_underrun), 32'd0);
        chk("rstmid_selected", 32'(bus.selected), 32'd0);
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        clks(2);
        rst_n = 1'b1;
        clks(2);
        rx_obs.delete();
        bus.cs_n = 1'b0;
        clks(SETUP);
        chk("rstmid_reselect_ready", 32'(bus.tx_ready), 32'd1);
        rx_exp.push_back(8'hE7);
        spi_bits(8'hE7, 8, 1'b1, mi);
        clks(HALF);
        chk("rstmid_fill_byte", 32'(mi), 32'hFF);
        check_rx("rstmid");
        bus.cs_n = 1'b1;
        clks(HALF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
